ide_sector_mover: RTL and testbench
===================================

# ide_sector_mover

Sector transfer engine on the IO-controller side of the IDE sector FIFO. It moves whole 256-word sectors between a 16-bit valid/ready stream from the IO controller and the FIFO's strobe port. In fill mode it writes sectors into the FIFO for the CPU to read. In drain mode it empties sectors the CPU wrote into the FIFO. It sits between the IO-controller bridge and the FIFO, runs on the bus clock, and is gated by the same clock enable.

## Interface
Parameters:
- WORDS_PER_SECTOR, 256: words per sector; must be a power of two, at most 256.

Ports:
- clk  in  1  bus clock.
- reset  in  1  synchronous, active-high; clears all state.
- clk_en  in  1  qualifies every state change; nothing advances when it is low.
- start  in  1  one-enabled-cycle pulse; sampled only in IDLE.
- dir  in  1  0 = fill (IO to FIFO), 1 = drain (FIFO to IO); latched at start.
- sector_count  in  8  number of sectors; 0 means 256; latched at start.
- abort  in  1  returns to IDLE at the next enabled edge.
- io_in_data / io_in_valid / io_in_ready  16/1/out 1  fill-mode input stream.
- io_out_data / io_out_valid / io_out_ready  out 16/out 1/in 1  drain-mode output stream.
- fifo_wdata  out  16  to the FIFO data input.
- fifo_wr  out  1  FIFO write strobe.
- fifo_rdata  in  16  from the FIFO data output.
- fifo_rd  out  1  FIFO read strobe.
- fifo_full, fifo_empty  in  1  FIFO status.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-enabled-cycle pulse after the last word of the last sector.
- sectors_left  out  9  sectors not yet completed.

## Operation
- States: IDLE, F_WAIT, F_WR, F_GAP, D_WAIT, D_RD, D_HOLD, D_OUT, FINISH.
- IDLE: on start, latch dir and sector_count (0 becomes 256). Clear the word counter. Go to F_WAIT when dir=0, D_WAIT when dir=1.
- Fill:
  - F_WAIT with word counter = 0: wait for fifo_full=0, so at most one unread sector is ahead of the CPU.
  - F_WAIT with word counter != 0: no FIFO gating.
  - io_in_ready=1 only in F_WAIT when the gate is satisfied.
  - On io_in_valid & io_in_ready: capture io_in_data into fifo_wdata and go to F_WR.
  - F_WR: fifo_wr=1 for exactly one enabled cycle. The FIFO stores the word while the strobe is high and advances its pointer on the falling edge.
  - F_GAP: fifo_wr=0 for one enabled cycle, then increment the word counter.
  - If the word completed a sector, decrement sectors_left. At 0 go to FINISH, otherwise go to F_WAIT.
- Drain:
  - D_WAIT: wait for fifo_empty=0, then go to D_RD.
  - D_RD: fifo_rd=1 for one enabled cycle; io_out_data <= fifo_rdata on the same edge that raises fifo_rd. The FIFO holds its output while rd is high and advances on the rising edge.
  - D_HOLD: fifo_rd=0 for one enabled cycle so the FIFO output and empty flag refresh.
  - D_OUT: io_out_valid=1 until io_out_ready. Then count the word, do sector accounting as in fill, and go to D_WAIT or FINISH.
- FINISH: pulse done for one enabled cycle, then go to IDLE.
- abort in any state goes to IDLE and clears fifo_wr, fifo_rd, io_out_valid and sectors_left. A strobe already high drops that cycle and the FIFO pointer still advances. FIFO reset is the owner's responsibility.
- Word counter width is log2(WORDS_PER_SECTOR) and wraps to 0 at each sector boundary. sectors_left is 9 bits wide so it can represent 256.

## Timing
- Reset values: all outputs 0; state IDLE; sectors_left=0.
- start to first io_in_ready (fill, FIFO not full): 1 enabled cycle.
- Fill cadence: 3 enabled cycles per word minimum (F_WAIT, F_WR, F_GAP). fifo_wr is never high on two consecutive enabled cycles.
- Drain cadence: 4 enabled cycles per word minimum (D_WAIT, D_RD, D_HOLD, D_OUT). There are always ≥2 enabled cycles with fifo_rd=0 between rd pulses.
- Back-pressure:
  - io_out_valid is held, with io_out_data stable, until accepted.
  - A stalled io_in_valid leaves fifo_wr low.
- clk_en low freezes all state and outputs.
- start while busy is ignored.
- start and abort together in IDLE: abort wins and the block stays idle.
- done rises one enabled cycle after the final F_GAP or the final D_OUT handshake.

## Test plan
- Fill one sector, FIFO initially empty, io_in_valid always 1:
  - exactly 256 fifo_wr pulses with data 0x0000..0x00FF in order;
  - done once;
  - sectors_left 1 to 0.
- Fill with sector_count=0:
  - sectors_left starts at 256;
  - sector 2 stalls with io_in_ready=0 while fifo_full=1;
  - it resumes within 1 enabled cycle of fifo_full falling.
- Drain 2 sectors:
  - preload 512 words 0xA000+i;
  - io_out_ready toggles randomly;
  - output equals the preload sequence;
  - fifo_rd gap is ≥2 enabled cycles.
- Drain with fifo_empty=1 asserted mid-sector: fifo_rd stays low and io_out_valid stays low until empty clears; no word is lost or duplicated.
- Abort at word 100 of a fill: IDLE next enabled edge, fifo_wr=0, busy=0, no done pulse.
- clk_en low for 5 cycles mid-transfer: state, strobes and outputs are unchanged; the word sequence is intact afterwards.

Source files
------------

// File: rtl/ide_sector_mover.sv
// Moves whole sectors between a 16-bit valid/ready stream and the IDE sector
// FIFO strobe port: fill writes into the FIFO, drain empties it.
module ide_sector_mover #(
  parameter int WORDS_PER_SECTOR = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic        dir,
  input  logic [7:0]  sector_count,
  input  logic        abort,
  input  logic [15:0] io_in_data,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  output logic [15:0] io_out_data,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [15:0] fifo_wdata,
  output logic        fifo_wr,
  input  logic [15:0] fifo_rdata,
  output logic        fifo_rd,
  input  logic        fifo_full,
  input  logic        fifo_empty,
  output logic        busy,
  output logic        done,
  output logic [8:0]  sectors_left
);

  localparam int WW =
    (WORDS_PER_SECTOR > 1) ? $clog2(WORDS_PER_SECTOR) : 1;
  localparam logic [WW-1:0] LAST = WW'(WORDS_PER_SECTOR - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_F_WAIT,
    S_F_WR,
    S_F_GAP,
    S_D_WAIT,
    S_D_RD,
    S_D_HOLD,
    S_D_OUT,
    S_FINISH
  } state_t;

  state_t        r_state;
  logic [WW-1:0] r_wcnt;
  logic [8:0]    r_left;
  logic [15:0]   r_wdata;
  logic [15:0]   r_odata;
  logic          r_wr;
  logic          r_rd;
  logic          r_ovalid;
  logic          r_done;

  logic          w_gate;
  logic          w_last_word;
  logic          w_last_sector;
  logic [WW-1:0] w_wcnt_nxt;
  logic [8:0]    w_left_nxt;

  // Only gate on a full FIFO at a sector boundary: one sector may be queued.
  assign w_gate        = (r_wcnt != '0) || !fifo_full;
  assign w_last_word   = (r_wcnt == LAST);
  assign w_last_sector = w_last_word && (r_left == 9'd1);
  assign w_wcnt_nxt    = w_last_word ? '0 : r_wcnt + 1'b1;
  assign w_left_nxt    = w_last_word ? r_left - 9'd1 : r_left;

  assign io_in_ready  = (r_state == S_F_WAIT) && w_gate;
  assign io_out_data  = r_odata;
  assign io_out_valid = r_ovalid;
  assign fifo_wdata   = r_wdata;
  assign fifo_wr      = r_wr;
  assign fifo_rd      = r_rd;
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign sectors_left = r_left;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wcnt   <= '0;
      r_left   <= '0;
      r_wdata  <= '0;
      r_odata  <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_ovalid <= 1'b0;
      r_done   <= 1'b0;
    end else if (clk_en) begin
      if (abort) begin
        r_state  <= S_IDLE;
        r_wr     <= 1'b0;
        r_rd     <= 1'b0;
        r_ovalid <= 1'b0;
        r_done   <= 1'b0;
        r_left   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_done <= 1'b0;
            if (start) begin
              r_left  <= (sector_count == 8'd0) ?
                         9'd256 : {1'b0, sector_count};
              r_wcnt  <= '0;
              r_state <= dir ? S_D_WAIT : S_F_WAIT;
            end
          end
          S_F_WAIT: begin
            if (io_in_valid && w_gate) begin
              r_wdata <= io_in_data;
              r_wr    <= 1'b1;
              r_state <= S_F_WR;
            end
          end
          S_F_WR: begin
            r_wr    <= 1'b0;
            r_state <= S_F_GAP;
          end
          S_F_GAP: begin
            r_wcnt  <= w_wcnt_nxt;
            r_left  <= w_left_nxt;
            r_done  <= w_last_sector;
            r_state <= w_last_sector ? S_FINISH : S_F_WAIT;
          end
          S_D_WAIT: begin
            if (!fifo_empty) begin
              r_odata <= fifo_rdata;
              r_rd    <= 1'b1;
              r_state <= S_D_RD;
            end
          end
          S_D_RD: begin
            r_rd    <= 1'b0;
            r_state <= S_D_HOLD;
          end
          S_D_HOLD: begin
            r_ovalid <= 1'b1;
            r_state  <= S_D_OUT;
          end
          S_D_OUT: begin
            if (io_out_ready) begin
              r_ovalid <= 1'b0;
              r_wcnt   <= w_wcnt_nxt;
              r_left   <= w_left_nxt;
              r_done   <= w_last_sector;
              r_state  <= w_last_sector ? S_FINISH : S_D_WAIT;
            end
          end
          S_FINISH: begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ide_sector_mover.sv
// Bench for ide_sector_mover: FIFO model, vector table for start/abort
// behaviour, and scoreboarded fill/drain sequences.
module tb_ide_sector_mover;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b1;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [7:0]  sector_count = 8'd0;
  logic        abort = 1'b0;
  logic [15:0] io_in_data = 16'd0;
  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [15:0] io_out_data;
  logic        io_out_valid;
  logic        io_out_ready = 1'b1;
  logic [15:0] fifo_wdata;
  logic        fifo_wr;
  logic [15:0] fifo_rdata;
  logic        fifo_rd;
  logic        fifo_full = 1'b0;
  logic        fifo_empty;
  logic        busy;
  logic        done;
  logic [8:0]  sectors_left;

  ide_sector_mover #(.WORDS_PER_SECTOR(256)) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .start(start),
    .dir(dir),
    .sector_count(sector_count),
    .abort(abort),
    .io_in_data(io_in_data),
    .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready),
    .io_out_data(io_out_data),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .fifo_wdata(fifo_wdata),
    .fifo_wr(fifo_wr),
    .fifo_rdata(fifo_rdata),
    .fifo_rd(fifo_rd),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .busy(busy),
    .done(done),
    .sectors_left(sectors_left)
  );

  initial forever #5 clk = ~clk;

  // drain-side FIFO model: preloaded by the bench, popped by fifo_rd
  logic [15:0] mem [0:1023];
  int wp = 0;
  int rp = 0;
  assign fifo_empty = (rp >= wp);
  assign fifo_rdata = mem[rp[9:0]];

  always @(posedge clk) begin
    if (reset) rp <= 0;
    else if (clk_en && fifo_rd) rp <= rp + 1;
  end

  logic rnd_en = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    io_out_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // observation side of the scoreboard
  logic [15:0] obs_mem [0:4095];
  int obs_wp = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, out_cnt = 0;
  int gap_bad = 0, wr2_bad = 0, stab_bad = 0, since_rd = 100;
  logic prev_wr = 1'b0, prev_v = 1'b0, prev_acc = 1'b0;
  logic [15:0] prev_d = 16'd0;

  always @(negedge clk) begin
    if (!reset && clk_en) begin
      if (fifo_wr) begin
        wr_cnt <= wr_cnt + 1;
        obs_mem[obs_wp[11:0]] <= fifo_wdata;
        obs_wp <= obs_wp + 1;
        if (prev_wr) wr2_bad <= wr2_bad + 1;
      end else if (io_out_valid && io_out_ready) begin
        out_cnt <= out_cnt + 1;
        obs_mem[obs_wp[11:0]] <= io_out_data;
        obs_wp <= obs_wp + 1;
      end
      if (fifo_rd) begin
        rd_cnt <= rd_cnt + 1;
        if (since_rd < 2) gap_bad <= gap_bad + 1;
        since_rd <= 0;
      end else begin
        since_rd <= since_rd + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (prev_v && !prev_acc &&
          (!io_out_valid || io_out_data != prev_d))
        stab_bad <= stab_bad + 1;
      prev_wr  <= fifo_wr;
      prev_v   <= io_out_valid;
      prev_acc <= io_out_ready;
      prev_d   <= io_out_data;
    end
  end

  int errors = 0;
  int checks = 0;
  int obs_rp = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic pos;
    @(posedge clk); #1;
  endtask

  task automatic nx;
    @(negedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (3) pos;
    reset = 1'b0;
  endtask

  task automatic pulse_start(input logic d, input logic [7:0] cnt,
                             input logic ab);
    pos;
    start = 1'b1;
    dir = d;
    sector_count = cnt;
    abort = ab;
    pos;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_abort;
    pos;
    abort = 1'b1;
    pos;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int g;
    g = 0;
    while (done_cnt == d0 && g < budget) begin
      nx;
      g++;
    end
    if (done_cnt == d0) timeout("wait_done");
  endtask

  task automatic sb_check(input string nm);
    logic [15:0] e;
    while (obs_rp < obs_wp) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: extra word %0h", nm, obs_mem[obs_rp[11:0]]);
      end else begin
        e = exp_q.pop_front();
        chk(nm, 32'(obs_mem[obs_rp[11:0]]), 32'(e));
      end
      obs_rp++;
    end
    chk({nm, "_missing"}, exp_q.size(), 0);
  endtask

  // Feed n words; optional clk_en freeze and abort right after a given word.
  task automatic send(input int n, input logic [15:0] base,
                      input int freeze_at, input int abort_at,
                      input int exp_sl);
    for (int i = 0; i < n; i++) begin
      int g;
      int d0;
      g = 0;
      pos;
      io_in_data = base + 16'(i);
      io_in_valid = 1'b1;
      nx;
      while (!(clk_en && io_in_ready) && g < 200) begin
        nx;
        g++;
      end
      if (!(clk_en && io_in_ready)) begin
        timeout("send");
        io_in_valid = 1'b0;
        return;
      end
      exp_q.push_back(io_in_data);
      if (i == freeze_at) begin
        pos;
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
          nx;
          chk("frz_wr", 32'(fifo_wr), 1);
          chk("frz_wdata", 32'(fifo_wdata), 32'(base + 16'(i)));
          chk("frz_busy", 32'(busy), 1);
          chk("frz_rdy", 32'(io_in_ready), 0);
          chk("frz_sl", 32'(sectors_left), exp_sl);
        end
        pos;
        clk_en = 1'b1;
      end
      if (i == abort_at) begin
        pos;
        abort = 1'b1;
        pos;
        abort = 1'b0;
        io_in_valid = 1'b0;
        nx;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_wr", 32'(fifo_wr), 0);
        chk("abort_sl", 32'(sectors_left), 0);
        chk("abort_rdy", 32'(io_in_ready), 0);
        d0 = done_cnt;
        repeat (10) nx;
        chk("abort_nodone", done_cnt, d0);
        return;
      end
    end
    pos;
  endtask

  typedef struct {
    logic       d;
    logic [7:0] cnt;
    logic       ab;
    logic       full;
    logic       e_busy;
    logic [8:0] e_sl;
    logic       e_rdy;
  } vec_t;

  vec_t tv [6];

  initial begin
    int d0;
    int w0;
    int r0;
    int bad;
    int g;

    tv[0] = '{d:1'b0, cnt:8'd1,   ab:1'b0, full:1'b0,
              e_busy:1'b1, e_sl:9'd1,   e_rdy:1'b1};
    tv[1] = '{d:1'b0, cnt:8'd0,   ab:1'b0, full:1'b0,
              e_busy:1'b1, e_sl:9'd256, e_rdy:1'b1};
    tv[2] = '{d:1'b1, cnt:8'd5,   ab:1'b0, full:1'b0,
              e_busy:1'b1, e_sl:9'd5,   e_rdy:1'b0};
    tv[3] = '{d:1'b0, cnt:8'd3,   ab:1'b1, full:1'b0,
              e_busy:1'b0, e_sl:9'd0,   e_rdy:1'b0};
    tv[4] = '{d:1'b1, cnt:8'd255, ab:1'b0, full:1'b0,
              e_busy:1'b1, e_sl:9'd255, e_rdy:1'b0};
    tv[5] = '{d:1'b0, cnt:8'd2,   ab:1'b0, full:1'b1,
              e_busy:1'b1, e_sl:9'd2,   e_rdy:1'b0};

    do_reset;
    nx;
    chk("reset_ctrl", 32'({busy, done, fifo_wr, fifo_rd,
                           io_out_valid, io_in_ready}), 0);
    chk("reset_sl", 32'(sectors_left), 0);
    chk("reset_data", {fifo_wdata, io_out_data}, 0);

    for (int i = 0; i < 6; i++) begin
      fifo_full = tv[i].full;
      pulse_start(tv[i].d, tv[i].cnt, tv[i].ab);
      nx;
      chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
      chk($sformatf("tv%0d_sl", i), 32'(sectors_left), 32'(tv[i].e_sl));
      chk($sformatf("tv%0d_rdy", i), 32'(io_in_ready), 32'(tv[i].e_rdy));
      do_abort;
      nx;
      chk($sformatf("tv%0d_idle", i), 32'(busy), 0);
      fifo_full = 1'b0;
    end

    pulse_start(1'b0, 8'd3, 1'b0);
    pulse_start(1'b1, 8'd7, 1'b0);
    nx;
    chk("busy_start_sl", 32'(sectors_left), 3);
    chk("busy_start_rdy", 32'(io_in_ready), 1);
    do_abort;

    // fill one sector, ready from the first enabled cycle after start
    do_reset;
    d0 = done_cnt;
    w0 = wr_cnt;
    pulse_start(1'b0, 8'd1, 1'b0);
    nx;
    chk("fill1_rdy", 32'(io_in_ready), 1);
    chk("fill1_sl0", 32'(sectors_left), 1);
    send(256, 16'h0000, -1, -1, 1);
    io_in_valid = 1'b0;
    wait_done(d0, 50);
    repeat (5) nx;
    chk("fill1_done", done_cnt, d0 + 1);
    chk("fill1_wr", wr_cnt, w0 + 256);
    chk("fill1_sl", 32'(sectors_left), 0);
    chk("fill1_busy", 32'(busy), 0);
    sb_check("fill1");

    // 256-sector fill: FIFO-full gate at the start of sector 2
    do_reset;
    pulse_start(1'b0, 8'd0, 1'b0);
    nx;
    chk("fill0_sl", 32'(sectors_left), 256);
    send(256, 16'h1000, 10, -1, 256);
    fifo_full = 1'b1;
    io_in_data = 16'h1100;
    w0 = wr_cnt;
    bad = 0;
    repeat (12) begin
      nx;
      if (io_in_ready) bad++;
    end
    chk("fill0_stall", bad, 0);
    chk("fill0_sl1", 32'(sectors_left), 255);
    chk("fill0_stall_wr", wr_cnt, w0 + 1);
    pos;
    fifo_full = 1'b0;
    nx;
    chk("fill0_resume", 32'(io_in_ready), 1);
    exp_q.push_back(16'h1100);
    send(3, 16'h1101, -1, -1, 255);
    io_in_valid = 1'b0;
    do_abort;
    nx;
    chk("fill0_abort_busy", 32'(busy), 0);
    chk("fill0_abort_sl", 32'(sectors_left), 0);
    sb_check("fill0");

    // freeze at word 50, abort at word 100
    do_reset;
    pulse_start(1'b0, 8'd2, 1'b0);
    send(200, 16'h2000, 50, 100, 2);
    chk("wr_b2b", wr2_bad, 0);
    sb_check("abortfill");

    // drain two sectors with random back-pressure
    wp = 0;
    do_reset;
    for (int i = 0; i < 512; i++) begin
      mem[i] = 16'hA000 + 16'(i);
      exp_q.push_back(16'hA000 + 16'(i));
    end
    wp = 512;
    rnd_en = 1'b1;
    d0 = done_cnt;
    pulse_start(1'b1, 8'd2, 1'b0);
    nx;
    chk("drain_sl", 32'(sectors_left), 2);
    chk("drain_busy", 32'(busy), 1);
    wait_done(d0, 20000);
    rnd_en = 1'b0;
    repeat (3) nx;
    chk("drain_done", done_cnt, d0 + 1);
    chk("drain_sl_end", 32'(sectors_left), 0);
    chk("drain_rd_gap", gap_bad, 0);
    chk("drain_hold", stab_bad, 0);
    chk("drain_pops", rp, 512);
    sb_check("drain2");

    // drain with the FIFO running empty mid-sector
    wp = 0;
    do_reset;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'hB000 + 16'(i);
      exp_q.push_back(16'hB000 + 16'(i));
    end
    wp = 100;
    r0 = out_cnt;
    d0 = done_cnt;
    pulse_start(1'b1, 8'd1, 1'b0);
    g = 0;
    while (out_cnt < r0 + 100 && g < 2000) begin
      nx;
      g++;
    end
    if (out_cnt < r0 + 100) timeout("empty_first100");
    r0 = rd_cnt;
    bad = 0;
    repeat (10) begin
      nx;
      if (io_out_valid || fifo_rd) bad++;
    end
    chk("empty_stall", bad, 0);
    chk("empty_rd", rd_cnt, r0);
    chk("empty_sl", 32'(sectors_left), 1);
    wp = 256;
    wait_done(d0, 5000);
    repeat (3) nx;
    chk("empty_sl_end", 32'(sectors_left), 0);
    chk("empty_pops", rp, 256);
    chk("empty_rd_gap", gap_bad, 0);
    sb_check("drain_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
